// File: rtl/gate_pkg.sv
// Shared types and helpers for the timed gate controller.
package gate_pkg;

  // Controller states; encoding is visible on state_o for status/debug.
  typedef enum logic [2:0] {
    ST_STOPPED = 3'd0,
    ST_OPENING = 3'd1,
    ST_OPEN    = 3'd2,
    ST_CLOSING = 3'd3,
    ST_CLOSED  = 3'd4,
    ST_FAULT   = 3'd5
  } gate_state_t;

  // Counter width able to hold the larger of the two cycle limits.
  function automatic int unsigned timer_width(input int unsigned auto_close,
                                              input int unsigned move_timeout);
    int unsigned m;
    m = (auto_close > move_timeout) ? auto_close : move_timeout;
    return $clog2(m + 1);
  endfunction

endpackage : gate_pkg

// File: rtl/gate_timer.sv
// Saturating up-counter with synchronous clear and count enable.
module gate_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o
);

  localparam logic [WIDTH-1:0] CntMax = '1;

  logic [WIDTH-1:0] cnt_q;

  // Clear wins over enable; the count holds at all-ones instead of wrapping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != CntMax)) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule : gate_timer

// File: rtl/gate_ctrl_timed.sv
// Gate motor controller: push-button open/close/reverse with obstacle
// reversal, auto-close from OPEN and a travel-timeout fault.
module gate_ctrl_timed
  import gate_pkg::*;
#(
  parameter int unsigned AUTO_CLOSE_CYC   = 8,
  parameter int unsigned MOVE_TIMEOUT_CYC = 32
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       btn_i,
  input  logic       fca_i,
  input  logic       fcc_i,
  input  logic       obst_i,
  output logic       abrir_o,
  output logic       fechar_o,
  output logic       fault_o,
  output logic [2:0] state_o
);

  localparam int unsigned TmrW = timer_width(AUTO_CLOSE_CYC, MOVE_TIMEOUT_CYC);
  localparam bit          AcEn = (AUTO_CLOSE_CYC != 0);

  // The timer reads N-1 at the N-th edge spent in a state, so the limits
  // compare against the count minus one.
  localparam int unsigned MvLastI = (MOVE_TIMEOUT_CYC == 0) ? 0 : MOVE_TIMEOUT_CYC - 1;
  localparam int unsigned AcLastI = (AUTO_CLOSE_CYC == 0) ? 0 : AUTO_CLOSE_CYC - 1;
  localparam logic [TmrW-1:0] MvLast = TmrW'(MvLastI);
  localparam logic [TmrW-1:0] AcLast = TmrW'(AcLastI);

  gate_state_t     state_q, state_d;
  logic            btn_q;
  logic            press;
  logic            both_lim;
  logic            tmr_clr, tmr_en;
  logic [TmrW-1:0] tmr_cnt;
  logic            mv_done, ac_done;
  logic            abrir_q, fechar_q, fault_q;

  assign press    = btn_i & ~btn_q;
  assign both_lim = fca_i & fcc_i;
  assign mv_done  = (tmr_cnt >= MvLast);
  assign ac_done  = AcEn && (tmr_cnt >= AcLast);

  // Button edge detector register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      btn_q <= 1'b0;
    end else begin
      btn_q <= btn_i;
    end
  end

  // Next-state logic and timer control.
  always_comb begin
    state_d = state_q;
    tmr_clr = 1'b1;
    tmr_en  = 1'b0;

    if ((state_q != ST_FAULT) && both_lim) begin
      state_d = ST_FAULT;
    end else begin
      unique case (state_q)
        ST_STOPPED: begin
          if (fca_i)       state_d = ST_OPEN;
          else if (fcc_i)  state_d = ST_CLOSED;
          else if (press)  state_d = ST_OPENING;
        end
        ST_OPENING: begin
          if (fca_i)        state_d = ST_OPEN;
          else if (press)   state_d = ST_CLOSING;
          else if (mv_done) state_d = ST_FAULT;
        end
        ST_CLOSING: begin
          if (fcc_i)        state_d = ST_CLOSED;
          else if (obst_i)  state_d = ST_OPENING;
          else if (press)   state_d = ST_OPENING;
          else if (mv_done) state_d = ST_FAULT;
        end
        ST_OPEN: begin
          if (!obst_i && (press || ac_done)) state_d = ST_CLOSING;
        end
        ST_CLOSED: begin
          if (press) state_d = ST_OPENING;
        end
        ST_FAULT: begin
          if (press && !both_lim) state_d = ST_STOPPED;
        end
        default: state_d = ST_FAULT;
      endcase
    end

    // Count only while staying in a timed state; a blocked beam holds OPEN at 0.
    if (state_d == state_q) begin
      unique case (state_q)
        ST_OPENING, ST_CLOSING: begin
          tmr_clr = 1'b0;
          tmr_en  = 1'b1;
        end
        ST_OPEN: begin
          if (!obst_i) begin
            tmr_clr = 1'b0;
            tmr_en  = 1'b1;
          end
        end
        default: begin
          tmr_clr = 1'b1;
          tmr_en  = 1'b0;
        end
      endcase
    end
  end

  // State register with outputs registered from the next state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_STOPPED;
      abrir_q  <= 1'b0;
      fechar_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      abrir_q  <= (state_d == ST_OPENING);
      fechar_q <= (state_d == ST_CLOSING);
      fault_q  <= (state_d == ST_FAULT);
    end
  end

  gate_timer #(
    .WIDTH (TmrW)
  ) u_timer (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (tmr_clr),
    .en_i   (tmr_en),
    .cnt_o  (tmr_cnt)
  );

  assign abrir_o  = abrir_q;
  assign fechar_o = fechar_q;
  assign fault_o  = fault_q;
  assign state_o  = 3'(state_q);

endmodule : gate_ctrl_timed

// File: tb/tb_gate_ctrl_timed.sv
// Self-checking bench for gate_ctrl_timed: vector table, directed corner
// sequences and random stimulus against a timestamp-based reference model.
module tb_gate_ctrl_timed;

  localparam int AC = 8;
  localparam int MT = 32;

  localparam logic [2:0] S_STOP = 3'd0;
  localparam logic [2:0] S_OPNG = 3'd1;
  localparam logic [2:0] S_OPEN = 3'd2;
  localparam logic [2:0] S_CLSG = 3'd3;
  localparam logic [2:0] S_CLSD = 3'd4;
  localparam logic [2:0] S_FLT  = 3'd5;

  logic       clk, rst_n;
  logic       btn, fca, fcc, obst;
  logic       abrir, fechar, fault;
  logic [2:0] state;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: current state, edge counter and edge of last (re)start.
  logic [2:0] m_st;
  logic       m_prev_btn;
  int         edge_no = 0;
  int         m_start = 0;

  typedef struct {
    logic       btn;
    logic       fca;
    logic       fcc;
    logic       obst;
    logic [2:0] exp_st;
  } vec_t;

  vec_t vecs[18];

  gate_ctrl_timed #(
    .AUTO_CLOSE_CYC   (AC),
    .MOVE_TIMEOUT_CYC (MT)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .btn_i    (btn),
    .fca_i    (fca),
    .fcc_i    (fcc),
    .obst_i   (obst),
    .abrir_o  (abrir),
    .fechar_o (fechar),
    .fault_o  (fault),
    .state_o  (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st       = S_STOP;
    m_prev_btn = 1'b0;
    m_start    = edge_no;
  endtask

  // One clock edge of the rules, using the inputs currently driven.
  task automatic model_edge();
    logic       press;
    logic [2:0] nxt;
    int         age;
    press      = btn && !m_prev_btn;
    m_prev_btn = btn;
    edge_no++;
    age = edge_no - m_start;
    nxt = m_st;
    if (m_st != S_FLT && fca && fcc) nxt = S_FLT;
    else begin
      case (m_st)
        S_STOP: if (fca) nxt = S_OPEN; else if (fcc) nxt = S_CLSD; else if (press) nxt = S_OPNG;
        S_OPNG: if (fca) nxt = S_OPEN; else if (press) nxt = S_CLSG; else if (age >= MT) nxt = S_FLT;
        S_CLSG: if (fcc) nxt = S_CLSD; else if (obst || press) nxt = S_OPNG;
                else if (age >= MT) nxt = S_FLT;
        S_OPEN: if (!obst && (press || (AC != 0 && age >= AC))) nxt = S_CLSG;
        S_CLSD: if (press) nxt = S_OPNG;
        S_FLT:  if (press && !(fca && fcc)) nxt = S_STOP;
        default: nxt = S_FLT;
      endcase
    end
    if (nxt != m_st || (m_st == S_OPEN && obst)) m_start = edge_no;
    m_st = nxt;
  endtask

  function automatic logic [5:0] model_outs();
    return {m_st, m_st == S_OPNG, m_st == S_CLSG, m_st == S_FLT};
  endfunction

  // Advance one edge, update the model and compare outputs just after the edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("model", {26'd0, state, abrir, fechar, fault}, {26'd0, model_outs()});
  endtask

  // Tick until state_o reaches target; n = edges taken, -1 if budget expired.
  task automatic wait_state(input logic [2:0] target, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (state == target) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    btn = 0; fca = 0; fcc = 0; obst = 0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("reset_outs", {28'd0, state, abrir, fechar, fault}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    int trans;
    logic [2:0] prev;

    //              btn fca fcc obst exp
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, S_STOP};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, S_OPNG};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, S_OPNG};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, S_OPEN};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, S_CLSG};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, S_OPNG};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, S_OPNG};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, S_CLSG};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, S_CLSD};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, S_OPNG};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, S_FLT};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, S_FLT};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, S_FLT};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, S_STOP};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, S_CLSD};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, S_OPNG};
    vecs[16] = '{1'b1, 1'b0, 1'b1, 1'b0, S_OPNG};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, S_OPNG};

    btn = 0; fca = 0; fcc = 0; obst = 0;
    rst_n = 1'b1;
    model_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_state", {28'd0, state, abrir, fechar, fault}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < 18; i++) begin
      btn = vecs[i].btn; fca = vecs[i].fca; fcc = vecs[i].fcc; obst = vecs[i].obst;
      tick();
      check($sformatf("vec%0d_state", i), {29'd0, state}, {29'd0, vecs[i].exp_st});
    end

    // Press, open for 10 cycles, then auto-close 8 edges after OPEN.
    do_reset();
    btn = 1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      btn = 0;
      if (abrir) n++;
    end
    check("open_travel_cycles", n, 10);
    fca = 1;
    tick();
    check("open_reached", {28'd0, state, abrir}, {28'd0, S_OPEN, 1'b0});
    wait_state(S_CLSG, 20, n);
    check("auto_close_edges", n, AC);
    fca = 0;
    tick();

    // Obstacle pulse during CLOSING reverses immediately.
    obst = 1;
    tick();
    obst = 0;
    check("obst_reverse", {30'd0, abrir, fechar}, 32'b10);

    // OPEN held by obstacle ignores presses, then auto-closes.
    fca = 1;
    tick();
    obst = 1;
    for (int i = 0; i < 20; i++) begin
      btn = (i % 4) < 2;
      tick();
    end
    check("obst_hold_open", {29'd0, state}, {29'd0, S_OPEN});
    btn = 0; obst = 0;
    wait_state(S_CLSG, 20, n);
    check("auto_close_after_obst", n, AC);
    fca = 0;

    // Travel timeout into FAULT, then press to STOPPED.
    fcc = 1;
    tick();
    fcc = 0; btn = 1;
    tick();
    btn = 0;
    wait_state(S_FLT, MT + 8, n);
    check("timeout_edges", n, MT);
    check("fault_outs", {29'd0, abrir, fechar, fault}, 32'b001);
    btn = 1;
    tick();
    btn = 0;
    check("fault_clear", {29'd0, state}, {29'd0, S_STOP});

    // Held button in CLOSED is a single press.
    fcc = 1;
    tick();
    fcc = 0; btn = 1;
    trans = 0;
    prev = state;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (state != prev) trans++;
      prev = state;
    end
    check("held_btn_transitions", trans, 1);
    check("held_btn_state", {29'd0, state}, {29'd0, S_OPNG});
    btn = 0;
    tick();
    btn = 1;
    tick();
    btn = 0;
    check("press_mid_travel", {29'd0, state}, {29'd0, S_CLSG});

    // Both limits active forces FAULT; a press cannot leave while they stay high.
    fca = 1; fcc = 1;
    tick();
    check("both_limits_fault", {29'd0, state}, {29'd0, S_FLT});
    btn = 1;
    tick();
    check("fault_sticky", {29'd0, state}, {29'd0, S_FLT});
    btn = 0; fca = 0; fcc = 0;
    tick();
    btn = 1;
    tick();
    btn = 0;
    tick();
    btn = 1;
    tick();
    btn = 0;
    tick();
    btn = 1;
    tick();
    btn = 0;
    tick();
    check("pre_reset_closing", {29'd0, state}, {29'd0, S_CLSG});
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_reset_mid", {28'd0, state, abrir, fechar, fault}, 32'd0);
    #1;
    rst_n = 1'b1;

    // Random stimulus against the reference model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) btn = ~btn;
      fca  = ($urandom_range(0, 15) == 0);
      fcc  = ($urandom_range(0, 15) == 0);
      obst = ($urandom_range(0, 9) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_gate_ctrl_timed
